// File: rtl/uart_slip_decode.sv
// SLIP (RFC 1055) decoder: raw UART bytes in, unescaped packets out with tlast/tuser.
// Define UART_SLIP_RX_ERR_EN to let rx_frame_error mark the current or next packet bad.
module uart_slip_decode #(
    parameter int MAX_LEN = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    input  logic       rx_frame_error,
    output logic       busy
);
    localparam logic [7:0]  END_B     = 8'hC0;
    localparam logic [7:0]  ESC_B     = 8'hDB;
    localparam logic [7:0]  ESC_END   = 8'hDC;
    localparam logic [7:0]  ESC_ESC   = 8'hDD;
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, DATA, ESC, DROP} state_t;

    state_t      state_q, state_d;
    logic        hold_full_q, hold_full_d;
    logic [7:0]  hold_data_q, hold_data_d;
    logic [15:0] len_q, len_d;
    logic        err_q, err_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        tuser_q, tuser_d;

    logic        accept;
    logic        dec_valid;
    logic        end_seen;
    logic        err_set;
    logic [7:0]  dec_byte;

    assign s_axis_tready = !tvalid_q || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            hold_data_q <= 8'h00;
            len_q       <= 16'd0;
            err_q       <= 1'b0;
            tdata_q     <= 8'h00;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            len_q       <= len_d;
            err_q       <= err_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        len_d       = len_q;
        err_d       = err_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tuser_d     = tuser_q;
        dec_valid   = 1'b0;
        dec_byte    = s_axis_tdata;
        end_seen    = 1'b0;
        err_set     = 1'b0;

        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                IDLE, DATA: begin
                    if (s_axis_tdata == END_B) begin
                        end_seen = 1'b1;
                    end else if (s_axis_tdata == ESC_B) begin
                        state_d = ESC;
                    end else begin
                        dec_valid = 1'b1;
                    end
                end
                ESC: begin
                    if (s_axis_tdata == ESC_END) begin
                        dec_valid = 1'b1;
                        dec_byte  = END_B;
                    end else if (s_axis_tdata == ESC_ESC) begin
                        dec_valid = 1'b1;
                        dec_byte  = ESC_B;
                    end else if (s_axis_tdata == END_B) begin
                        err_set  = 1'b1;
                        end_seen = 1'b1;
                    end else begin
                        dec_valid = 1'b1;
                        err_set   = 1'b1;
                    end
                end
                DROP: begin
                    if (s_axis_tdata == END_B) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            // The output slot is known free here, since accept implies s_axis_tready.
            if (end_seen) begin
                if (hold_full_q) begin
                    tvalid_d = 1'b1;
                    tdata_d  = hold_data_q;
                    tlast_d  = 1'b1;
                    tuser_d  = err_q || err_set;
                end
                hold_full_d = 1'b0;
                len_d       = 16'd0;
                err_d       = 1'b0;
                state_d     = IDLE;
            end else if (dec_valid) begin
                if (len_q == MAX_LEN_W) begin
                    if (hold_full_q) begin
                        tvalid_d = 1'b1;
                        tdata_d  = hold_data_q;
                        tlast_d  = 1'b1;
                        tuser_d  = 1'b1;
                    end
                    hold_full_d = 1'b0;
                    len_d       = 16'd0;
                    err_d       = 1'b0;
                    state_d     = DROP;
                end else begin
                    if (hold_full_q) begin
                        tvalid_d = 1'b1;
                        tdata_d  = hold_data_q;
                        tlast_d  = 1'b0;
                        tuser_d  = 1'b0;
                    end
                    hold_data_d = dec_byte;
                    hold_full_d = 1'b1;
                    len_d       = len_q + 16'd1;
                    state_d     = DATA;
                    if (err_set) begin
                        err_d = 1'b1;
                    end
                end
            end
        end

`ifdef UART_SLIP_RX_ERR_EN
        // Applied last so an error coinciding with END marks the following packet.
        if (rx_frame_error) begin
            err_d = 1'b1;
        end
`endif
    end

`ifndef UART_SLIP_RX_ERR_EN
    logic unused_rx_err;
    assign unused_rx_err = rx_frame_error;
`endif

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign busy          = hold_full_q || (state_q == ESC) || (state_q == DROP);

endmodule

// File: tb/tb_uart_slip_decode.sv
// Directed bench for uart_slip_decode: packet-level SLIP model plus literal expectations.
module tb_uart_slip_decode;
    localparam int MAX_LEN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic       m_axis_tlast;
    logic       m_axis_tuser;
    logic       rx_frame_error = 1'b0;
    logic       busy;

    always #5 clk = ~clk;

    uart_slip_decode #(.MAX_LEN(MAX_LEN)) dut (
        .clk(clk),
        .rst(rst),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser),
        .rx_frame_error(rx_frame_error),
        .busy(busy)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      got_q[$];
    beat_t      seen_q[$];
    beat_t      lit_q[$];
    logic [7:0] pkt[$];
    bit         m_esc = 1'b0;
    bit         m_drop = 1'b0;
    bit         m_bad = 1'b0;

    int    n_pass = 0;
    int    n_total = 0;
    int    bp_mode = 0;
    bit    busy_chk = 1'b0;
    bit    prev_stall = 1'b0;
    beat_t prev_beat;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endfunction

    // Packet-level model: a packet's beats become known once it closes or overflows.
    function automatic void model_flush(bit bad);
        beat_t b;
        for (int i = 0; i < pkt.size(); i++) begin
            b.d = pkt[i];
            b.l = (i == pkt.size() - 1);
            b.u = b.l ? bad : 1'b0;
            exp_q.push_back(b);
        end
        pkt.delete();
    endfunction

    function automatic void model_end();
        if (pkt.size() > 0) model_flush(m_bad);
        m_bad = 1'b0;
    endfunction

    function automatic void model_dec(logic [7:0] d);
        if (pkt.size() == MAX_LEN) begin
            model_flush(1'b1);
            m_bad  = 1'b0;
            m_drop = 1'b1;
        end else begin
            pkt.push_back(d);
        end
    endfunction

    function automatic void model_feed(logic [7:0] b);
        if (m_drop) begin
            if (b == 8'hC0) m_drop = 1'b0;
        end else if (m_esc) begin
            m_esc = 1'b0;
            if (b == 8'hDC) model_dec(8'hC0);
            else if (b == 8'hDD) model_dec(8'hDB);
            else if (b == 8'hC0) begin m_bad = 1'b1; model_end(); end
            else begin m_bad = 1'b1; model_dec(b); end
        end else if (b == 8'hC0) model_end();
        else if (b == 8'hDB) m_esc = 1'b1;
        else model_dec(b);
    endfunction

    function automatic void model_reset();
        pkt.delete();
        exp_q.delete();
        got_q.delete();
        seen_q.delete();
        m_esc = 1'b0;
        m_drop = 1'b0;
        m_bad = 1'b0;
    endfunction

    function automatic void lit(logic [7:0] d, logic l, logic u);
        beat_t b;
        b.d = d;
        b.l = l;
        b.u = u;
        lit_q.push_back(b);
    endfunction

    function automatic void check_lit(string nm);
        chk({nm, "_count"}, seen_q.size(), lit_q.size());
        for (int i = 0; i < lit_q.size() && i < seen_q.size(); i++)
            chk(nm, {seen_q[i].d, seen_q[i].l, seen_q[i].l & seen_q[i].u},
                {lit_q[i].d, lit_q[i].l, lit_q[i].u});
        lit_q.delete();
        seen_q.delete();
    endfunction

    always @(posedge clk) begin
        #2;
        if (bp_mode == 0) m_axis_tready = 1'b1;
        else if (bp_mode == 1) m_axis_tready = 1'b0;
        else m_axis_tready = ~m_axis_tready;
    end

    always @(negedge clk) begin
        beat_t g;
        beat_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            chk("s_tready", s_axis_tready, !m_axis_tvalid || m_axis_tready);
            if (prev_stall)
                chk("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser},
                    {1'b1, prev_beat});
            if (busy_chk) chk("busy_idle", busy, 0);
            if (m_axis_tvalid && m_axis_tready) begin
                g = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
                got_q.push_back(g);
                seen_q.push_back(g);
            end
            while (got_q.size() > 0 && exp_q.size() > 0) begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                chk("beat", {g.d, g.l, g.l & g.u}, {e.d, e.l, e.u});
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
        end
    end

    task automatic send_byte(logic [7:0] b);
        bit rdy = 1'b0;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 200 && !rdy; i++) begin
            @(negedge clk);
            rdy = s_axis_tready;
            @(posedge clk);
            #1;
        end
        chk("accept", rdy, 1);
        if (rdy) model_feed(b);
    endtask

    task automatic send_seq(input logic [7:0] v[$]);
        foreach (v[i]) send_byte(v[i]);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain(string nm);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk);
            #1;
            done = (exp_q.size() == 0) && (got_q.size() == 0) && !m_axis_tvalid;
        end
        chk({nm, "_drain"}, done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v[$];
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tvalid", m_axis_tvalid, 0);
        chk("reset_tlast", m_axis_tlast, 0);
        chk("reset_tuser", m_axis_tuser, 0);
        chk("reset_tdata", m_axis_tdata, 0);
        chk("reset_busy", busy, 0);
        chk("reset_s_tready", s_axis_tready, 1);
        @(posedge clk);
        #1;

        v = '{8'hC0, 8'h01, 8'h02, 8'h03, 8'hC0};
        send_seq(v);
        drain("t1");
        lit(8'h01, 0, 0); lit(8'h02, 0, 0); lit(8'h03, 1, 0);
        check_lit("t1");

        v = '{8'h01, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'h02, 8'hC0};
        send_seq(v);
        drain("t2");
        lit(8'h01, 0, 0); lit(8'hC0, 0, 0); lit(8'hDB, 0, 0); lit(8'h02, 1, 0);
        check_lit("t2");

        busy_chk = 1'b1;
        v = '{8'hC0, 8'hC0, 8'hC0};
        send_seq(v);
        repeat (3) @(posedge clk);
        #1;
        busy_chk = 1'b0;
        drain("t3");
        check_lit("t3");

        v = '{8'hDB, 8'h41, 8'h05, 8'hC0, 8'h07, 8'hC0};
        send_seq(v);
        drain("t4");
        lit(8'h41, 0, 0); lit(8'h05, 1, 1); lit(8'h07, 1, 0);
        check_lit("t4");

        v = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hDB, 8'h06, 8'hC0, 8'h09, 8'hC0};
        send_seq(v);
        drain("t5");
        lit(8'h01, 0, 0); lit(8'h02, 0, 0); lit(8'h03, 0, 0); lit(8'h04, 1, 1);
        lit(8'h09, 1, 0);
        check_lit("t5");

        v = '{8'h01, 8'hDB, 8'hC0, 8'h22, 8'hC0};
        send_seq(v);
        drain("t8");
        lit(8'h01, 1, 1); lit(8'h22, 1, 0);
        check_lit("t8");

        bp_mode = 2;
        v = '{8'h01, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'h02, 8'hC0, 8'h55, 8'hC0};
        send_seq(v);
        drain("t7");
        bp_mode = 0;
        lit(8'h01, 0, 0); lit(8'hC0, 0, 0); lit(8'hDB, 0, 0); lit(8'h02, 1, 0);
        lit(8'h55, 1, 0);
        check_lit("t7");

        bp_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        v = '{8'hC0, 8'h01, 8'h02};
        send_seq(v);
        s_axis_tdata  = 8'h03;
        s_axis_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_tvalid", m_axis_tvalid, 1);
        chk("t6_tdata", m_axis_tdata, 8'h01);
        chk("t6_tlast", m_axis_tlast, 0);
        chk("t6_s_tready", s_axis_tready, 0);
        chk("t6_busy", busy, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        model_reset();
        @(negedge clk);
        chk("t6_rst_tvalid", m_axis_tvalid, 0);
        chk("t6_rst_busy", busy, 0);
        bp_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        v = '{8'h0A, 8'h0B, 8'hC0};
        send_seq(v);
        drain("t6");
        lit(8'h0A, 0, 0); lit(8'h0B, 1, 0);
        check_lit("t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
